// File: rtl/door_control_pkg.sv
// -----------------------------------------------------------------------------
// door_control_pkg
//   Shared types and constants for the door lock controller.
//   - state_t          : controller state encoding (LOCKED, UNLOCKED, ALARM)
//   - PW_W             : width of every password value
//   - DEFAULT_PASSWORD : power-up value of the stored password
//   - CNT_W            : width of the consecutive-failure counter
// -----------------------------------------------------------------------------
package door_control_pkg;

  localparam int PW_W  = 14;
  localparam int CNT_W = 3;

  localparam logic [PW_W-1:0] DEFAULT_PASSWORD = 14'd1111;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    ALARM    = 2'd2
  } state_t;

endpackage

// File: rtl/door_attempt_counter.sv
// -----------------------------------------------------------------------------
// door_attempt_counter
//   Saturating count of consecutive failed password attempts.
//
//   Parameters:
//     MAX_ATTEMPTS : saturation value (legal range 1..7)
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous active-high reset, clears the count
//     clr    in   clear the count; with inc also high the count loads 1
//                 (a failed attempt that restarts the sequence)
//     inc    in   one more failed attempt
//     at_max out  combinational: the count being written this cycle equals
//                 MAX_ATTEMPTS because of an increment
// -----------------------------------------------------------------------------
module door_attempt_counter
  import door_control_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ATTEMPTS);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Never wraps: once at MAX_C further increments hold the value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_C) ? MAX_C : v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = inc ? CNT_W'(1) : '0;
    else if (inc)
      cnt_nxt = sat_inc(cnt);
  end

  assign at_max = inc && (cnt_nxt == MAX_C);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/door_control.sv
// -----------------------------------------------------------------------------
// door_control
//   Password-protected door lock controller. Authenticates keypad codes
//   against a stored password, drives the lock actuator and latches an alarm
//   after MAX_ATTEMPTS consecutive failed submits.
//
//   Parameters:
//     MAX_ATTEMPTS : consecutive failures that trigger ALARM (1..7)
//   Ports:
//     clk             in   system clock
//     reset           in   synchronous active-high reset (highest priority)
//     submit          in   1-cycle pulse: compare password_in with stored pw
//     password_in     in   keypad code (PW_W bits)
//     new_password    in   replacement code (PW_W bits)
//     change_password in   overwrite stored pw (honoured only in UNLOCKED)
//     unlock_button   in   inside manual release
//     ms_button       in   return-to-main-menu / relock
//     unlock_signal   out  door unlocked   (registered, Moore)
//     lock_signal     out  door locked     (registered, Moore)
//     alarm_signal    out  alarm active    (registered, Moore)
//
//   Build option:
//     DOOR_RESET_PASSWORD_EN : when defined, reset also restores the stored
//                              password to DEFAULT_PASSWORD. When undefined
//                              the stored password survives reset.
// -----------------------------------------------------------------------------
module door_control
  import door_control_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            submit,
  input  logic [PW_W-1:0] password_in,
  input  logic [PW_W-1:0] new_password,
  input  logic            change_password,
  input  logic            unlock_button,
  input  logic            ms_button,
  output logic            unlock_signal,
  output logic            lock_signal,
  output logic            alarm_signal
);

  state_t          state;
  state_t          state_nxt;
  logic [PW_W-1:0] stored_pw = DEFAULT_PASSWORD;
  logic            pw_match;
  logic            pw_we;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            cnt_at_max;

  assign pw_match = (password_in == stored_pw);

  door_attempt_counter #(
    .MAX_ATTEMPTS (MAX_ATTEMPTS)
  ) u_attempt_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .at_max (cnt_at_max)
  );

  // Next-state, counter control and password write enable. A mismatch from
  // UNLOCKED asserts clr and inc together so the counter restarts at 1.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    pw_we     = 1'b0;
    case (state)
      LOCKED: begin
        if (submit) begin
          if (pw_match) begin
            state_nxt = UNLOCKED;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = cnt_at_max ? ALARM : LOCKED;
          end
        end else if (unlock_button) begin
          state_nxt = UNLOCKED;
          cnt_clr   = 1'b1;
        end
      end
      UNLOCKED: begin
        if (ms_button) begin
          state_nxt = LOCKED;
          cnt_clr   = 1'b1;
        end else if (submit) begin
          if (pw_match) begin
            cnt_clr = 1'b1;
          end else begin
            cnt_clr   = 1'b1;
            cnt_inc   = 1'b1;
            state_nxt = cnt_at_max ? ALARM : LOCKED;
          end
        end else if (change_password) begin
          pw_we = 1'b1;
        end
      end
      ALARM:   state_nxt = ALARM;
      default: state_nxt = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOCKED;
      unlock_signal <= 1'b0;
      lock_signal   <= 1'b1;
      alarm_signal  <= 1'b0;
`ifdef DOOR_RESET_PASSWORD_EN
      stored_pw     <= DEFAULT_PASSWORD;
`endif
    end else begin
      state         <= state_nxt;
      unlock_signal <= (state_nxt == UNLOCKED);
      lock_signal   <= (state_nxt != UNLOCKED);
      alarm_signal  <= (state_nxt == ALARM);
      if (pw_we)
        stored_pw <= new_password;
    end
  end

endmodule

// File: tb/tb_door_control.sv
module tb_door_control;
  import door_control_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            submit = 1'b0;
  logic [PW_W-1:0] password_in = '0;
  logic [PW_W-1:0] new_password = '0;
  logic            change_password = 1'b0;
  logic            unlock_button = 1'b0;
  logic            ms_button = 1'b0;
  logic            unlock_signal;
  logic            lock_signal;
  logic            alarm_signal;

  int n_cmp = 0;
  int n_err = 0;
  logic [PW_W-1:0] cur_pw;

  door_control #(.MAX_ATTEMPTS(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .submit          (submit),
    .password_in     (password_in),
    .new_password    (new_password),
    .change_password (change_password),
    .unlock_button   (unlock_button),
    .ms_button       (ms_button),
    .unlock_signal   (unlock_signal),
    .lock_signal     (lock_signal),
    .alarm_signal    (alarm_signal)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, clock once, sample 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic sub, input logic [PW_W-1:0] pw,
                     input logic chg, input logic [PW_W-1:0] npw,
                     input logic ub, input logic ms);
    reset           = rst;
    submit          = sub;
    password_in     = pw;
    change_password = chg;
    new_password    = npw;
    unlock_button   = ub;
    ms_button       = ms;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    submit          = 1'b0;
    change_password = 1'b0;
    unlock_button   = 1'b0;
    ms_button       = 1'b0;
  endtask

  // Expected {unlock, lock, alarm, fail_cnt}
  task automatic chk(input string tag, input logic u, input logic l, input logic a,
                     input logic [2:0] c);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {unlock_signal, lock_signal, alarm_signal, dut.u_attempt_cnt.cnt};
    exp = {u, l, a, c};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed u/l/a/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, obs[5], obs[4], obs[3], obs[2:0], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // reset
    cyc(1, 0, 14'd0, 0, 14'd0, 0, 0);        chk("reset", 0, 1, 0, 0);
    cyc(0, 0, 14'd0, 0, 14'd0, 0, 0);        chk("idle_locked", 0, 1, 0, 0);
    // default password unlocks
    cyc(0, 1, 14'd1111, 0, 14'd0, 0, 0);     chk("unlock_default", 1, 0, 0, 0);
    // change password in UNLOCKED
    cyc(0, 0, 14'd0, 1, 14'd2222, 0, 0);     chk("change_pw", 1, 0, 0, 0);
    cyc(0, 1, 14'd2222, 0, 14'd0, 0, 0);     chk("new_pw_match_stay", 1, 0, 0, 0);
    cyc(0, 1, 14'd1111, 0, 14'd0, 0, 0);     chk("old_pw_mismatch", 0, 1, 0, 1);
    cyc(0, 0, 14'd0, 0, 14'd0, 1, 0);        chk("unlock_button", 1, 0, 0, 0);
    // three failures -> alarm
    cyc(0, 1, 14'd1234, 0, 14'd0, 0, 0);     chk("fail1_from_unlocked", 0, 1, 0, 1);
    cyc(0, 1, 14'd5678, 0, 14'd0, 1, 0);     chk("fail2_submit_beats_button", 0, 1, 0, 2);
    cyc(0, 1, 14'd9012, 0, 14'd0, 0, 0);     chk("fail3_alarm", 0, 1, 1, 3);
    cyc(0, 0, 14'd0, 0, 14'd0, 1, 0);        chk("alarm_ignores_unlock", 0, 1, 1, 3);
    cyc(0, 0, 14'd0, 0, 14'd0, 0, 1);        chk("alarm_ignores_ms", 0, 1, 1, 3);
    cyc(0, 1, 14'd2222, 0, 14'd0, 0, 0);     chk("alarm_ignores_good_pw", 0, 1, 1, 3);
    cyc(0, 1, 14'd9999, 1, 14'd0, 0, 0);     chk("alarm_cnt_saturates", 0, 1, 1, 3);
    // reset leaves alarm
    cyc(1, 0, 14'd0, 0, 14'd0, 0, 0);        chk("reset_from_alarm", 0, 1, 0, 0);
`ifdef DOOR_RESET_PASSWORD_EN
    cyc(0, 1, 14'd2222, 0, 14'd0, 0, 0);     chk("pw_restored_2222_fails", 0, 1, 0, 1);
    cyc(0, 1, 14'd1111, 0, 14'd0, 0, 0);     chk("pw_restored_1111_ok", 1, 0, 0, 0);
    cur_pw = 14'd1111;
`else
    cyc(0, 1, 14'd2222, 0, 14'd0, 0, 0);     chk("pw_survives_reset", 1, 0, 0, 0);
    cur_pw = 14'd2222;
`endif
    // ms_button relock, ignored in LOCKED, then manual release
    cyc(0, 0, 14'd0, 0, 14'd0, 0, 1);        chk("ms_relock", 0, 1, 0, 0);
    cyc(0, 0, 14'd0, 0, 14'd0, 0, 1);        chk("ms_ignored_locked", 0, 1, 0, 0);
    cyc(0, 0, 14'd0, 1, 14'd0555, 0, 0);     chk("chg_ignored_locked", 0, 1, 0, 0);
    cyc(0, 1, 14'd0555, 0, 14'd0, 0, 0);     chk("chg_in_locked_dropped", 0, 1, 0, 1);
    cyc(0, 0, 14'd0, 0, 14'd0, 1, 0);        chk("release_button", 1, 0, 0, 0);
    cyc(0, 1, 14'd7777, 0, 14'd0, 0, 1);     chk("ms_beats_submit", 0, 1, 0, 0);
    // success clears the failure count
    cyc(0, 1, 14'd0001, 0, 14'd0, 0, 0);     chk("clr_fail1", 0, 1, 0, 1);
    cyc(0, 1, 14'd0002, 0, 14'd0, 0, 0);     chk("clr_fail2", 0, 1, 0, 2);
    cyc(0, 1, cur_pw, 0, 14'd0, 0, 0);       chk("clr_success", 1, 0, 0, 0);
    cyc(0, 1, 14'd0003, 0, 14'd0, 0, 0);     chk("clr_fail1b", 0, 1, 0, 1);
    cyc(0, 1, 14'd0004, 0, 14'd0, 0, 0);     chk("clr_fail2b_no_alarm", 0, 1, 0, 2);
    // reset wins over a correct submit
    cyc(1, 1, cur_pw, 0, 14'd0, 1, 0);       chk("reset_beats_submit", 0, 1, 0, 0);
    // submit together with change_password: old password used, change dropped
    cyc(0, 0, 14'd0, 0, 14'd0, 1, 0);        chk("release_again", 1, 0, 0, 0);
    cyc(0, 1, cur_pw, 1, 14'd3333, 0, 0);    chk("submit_chg_match", 1, 0, 0, 0);
    cyc(0, 1, 14'd3333, 0, 14'd0, 0, 0);     chk("chg_was_dropped", 0, 1, 0, 1);
    cyc(0, 1, cur_pw, 0, 14'd0, 0, 0);       chk("old_pw_kept", 1, 0, 0, 0);
    // single-bit difference is a mismatch
    cyc(0, 1, cur_pw ^ 14'h2000, 0, 14'd0, 0, 0); chk("msb_diff_mismatch", 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
